// File: rtl/swt_debounce_if.sv
// ---------------------------------------------------------------------------
// swt_debounce_if
// Bundle of switch signals between the raw board switches, the debouncer and
// the downstream blink logic.
//
//   swt_raw  : raw, asynchronous switch levels        (master -> slave)
//   swt_db   : debounced, registered levels           (slave  -> master)
//   swt_rise : one-cycle pulse on a swt_db 0->1 change (slave  -> master)
//   swt_fall : one-cycle pulse on a swt_db 1->0 change (slave  -> master)
//
// The debouncer connects through the slave modport; whatever supplies the raw
// switches and consumes the conditioned levels uses the master modport.
// ---------------------------------------------------------------------------
interface swt_debounce_if #(
    parameter int WIDTH = 4
);
    logic [WIDTH-1:0] swt_raw;
    logic [WIDTH-1:0] swt_db;
    logic [WIDTH-1:0] swt_rise;
    logic [WIDTH-1:0] swt_fall;

    modport master (
        output swt_raw,
        input  swt_db,
        input  swt_rise,
        input  swt_fall
    );

    modport slave (
        input  swt_raw,
        output swt_db,
        output swt_rise,
        output swt_fall
    );
endinterface

// File: rtl/swt_debounce.sv
// ---------------------------------------------------------------------------
// swt_debounce
// Synchronizes raw board switches into the clk domain, debounces each bit
// independently and provides per-bit rise/fall pulses.
//
// Parameters:
//   WIDTH      : number of switch bits
//   DEB_CYCLES : consecutive cycles a new level must persist (2..65535)
//   CNT_W      : debounce counter width, 2**CNT_W > DEB_CYCLES
//
// Ports:
//   clk   : system clock, rising edge
//   rstb  : asynchronous active-low reset
//   bus   : swt_debounce_if.slave (swt_raw in; swt_db, swt_rise, swt_fall out)
//
// Build option:
//   SWT_DEBOUNCE_EDGE_EN : when defined, the rise/fall pulse registers are
//                          built; otherwise swt_rise/swt_fall are tied to 0.
//
// A level change that holds from before edge E1 appears on swt_db (and the
// matching pulse) at edge E(DEB_CYCLES+2): two synchronizer edges, one edge to
// enter the wait state, then DEB_CYCLES-1 counting edges.
// ---------------------------------------------------------------------------
module swt_debounce #(
    parameter int WIDTH      = 4,
    parameter int DEB_CYCLES = 16,
    parameter int CNT_W      = 16
) (
    input  logic          clk,
    input  logic          rstb,
    swt_debounce_if.slave bus
);

    typedef enum logic [1:0] {
        LOW_STABLE  = 2'd0,
        WAIT_HIGH   = 2'd1,
        HIGH_STABLE = 2'd2,
        WAIT_LOW    = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

    // Two-flop synchronizer; r_s2 is the only sampled view of the switches.
    logic [WIDTH-1:0] r_s1;
    logic [WIDTH-1:0] r_s2;

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            r_s1 <= '0;
            r_s2 <= '0;
        end else begin
            r_s1 <= bus.swt_raw;
            r_s2 <= r_s1;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_bit
            state_t           r_state;
            logic [CNT_W-1:0] r_cnt;
            logic             r_db;
            logic             w_acc_high;
            logic             w_acc_low;

            // Acceptance happens on the edge that sees the new level for the
            // DEB_CYCLES-th consecutive time.
            assign w_acc_high = (r_state == WAIT_HIGH) &&  r_s2[gi] && (r_cnt == CNT_LAST);
            assign w_acc_low  = (r_state == WAIT_LOW)  && !r_s2[gi] && (r_cnt == CNT_LAST);

            always_ff @(posedge clk or negedge rstb) begin
                if (!rstb) begin
                    r_state <= LOW_STABLE;
                    r_cnt   <= '0;
                    r_db    <= 1'b0;
                end else begin
                    case (r_state)
                        LOW_STABLE: begin
                            if (r_s2[gi]) begin
                                r_state <= WAIT_HIGH;
                                r_cnt   <= CNT_ONE;
                            end else begin
                                r_cnt   <= '0;
                            end
                        end
                        WAIT_HIGH: begin
                            if (!r_s2[gi]) begin
                                r_state <= LOW_STABLE;
                                r_cnt   <= '0;
                            end else if (w_acc_high) begin
                                r_state <= HIGH_STABLE;
                                r_db    <= 1'b1;
                                r_cnt   <= '0;
                            end else begin
                                r_cnt   <= r_cnt + CNT_ONE;
                            end
                        end
                        HIGH_STABLE: begin
                            if (!r_s2[gi]) begin
                                r_state <= WAIT_LOW;
                                r_cnt   <= CNT_ONE;
                            end else begin
                                r_cnt   <= '0;
                            end
                        end
                        WAIT_LOW: begin
                            if (r_s2[gi]) begin
                                r_state <= HIGH_STABLE;
                                r_cnt   <= '0;
                            end else if (w_acc_low) begin
                                r_state <= LOW_STABLE;
                                r_db    <= 1'b0;
                                r_cnt   <= '0;
                            end else begin
                                r_cnt   <= r_cnt + CNT_ONE;
                            end
                        end
                        default: begin
                            r_state <= LOW_STABLE;
                            r_cnt   <= '0;
                        end
                    endcase
                end
            end

            assign bus.swt_db[gi] = r_db;

`ifdef SWT_DEBOUNCE_EDGE_EN
            // Pulses are registered alongside r_db so they coincide with the
            // first cycle of the new debounced level. Acceptance of rise and
            // fall are mutually exclusive states, so both never fire together.
            logic r_rise;
            logic r_fall;

            always_ff @(posedge clk or negedge rstb) begin
                if (!rstb) begin
                    r_rise <= 1'b0;
                    r_fall <= 1'b0;
                end else begin
                    r_rise <= w_acc_high;
                    r_fall <= w_acc_low;
                end
            end

            assign bus.swt_rise[gi] = r_rise;
            assign bus.swt_fall[gi] = r_fall;
`else
            assign bus.swt_rise[gi] = 1'b0;
            assign bus.swt_fall[gi] = 1'b0;
`endif
        end
    endgenerate

endmodule

// File: tb/tb_swt_debounce.sv
// ---------------------------------------------------------------------------
// tb_swt_debounce
// Directed bench for swt_debounce (WIDTH=4, DEB_CYCLES=16, 8 ns clock).
// Expected pulse values are forced to 0 when SWT_DEBOUNCE_EDGE_EN is not
// defined, since the pulse outputs are then tied off.
// ---------------------------------------------------------------------------
module tb_swt_debounce;

    localparam int W   = 4;
    localparam int DEB = 16;

`ifdef SWT_DEBOUNCE_EDGE_EN
    localparam bit EDGE_ON = 1'b1;
`else
    localparam bit EDGE_ON = 1'b0;
`endif

    logic clk  = 1'b0;
    logic rstb = 1'b0;

    always #4 clk = ~clk;

    swt_debounce_if #(.WIDTH(W)) bus ();

    swt_debounce #(
        .WIDTH      (W),
        .DEB_CYCLES (DEB),
        .CNT_W      (16)
    ) u_dut (
        .clk  (clk),
        .rstb (rstb),
        .bus  (bus.slave)
    );

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [3:0] raw;
        int         n_edges;
        logic [3:0] db;
        logic [3:0] rise;
        logic [3:0] fall;
    } vec_t;

    vec_t vecs[17];

    // Advance one rising edge and settle 1 ns past it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [3:0] db_e,
                       input logic [3:0] rise_e, input logic [3:0] fall_e);
        logic [3:0] re;
        logic [3:0] fe;
        re = EDGE_ON ? rise_e : 4'b0000;
        fe = EDGE_ON ? fall_e : 4'b0000;
        checks++;
        if ({bus.swt_db, bus.swt_rise, bus.swt_fall} !== {db_e, re, fe}) begin
            errors++;
            $display("FAIL %s: got db=%b rise=%b fall=%b, want db=%b rise=%b fall=%b",
                     name, bus.swt_db, bus.swt_rise, bus.swt_fall, db_e, re, fe);
        end
    endtask

    initial begin
        logic quiet;
        logic [3:0] edb;
        logic [3:0] erise;
        logic [3:0] efall;

        // raw, edges, db, rise, fall  (checked after the last edge of each row)
        vecs[0]  = '{4'b1111, 17, 4'b0000, 4'b0000, 4'b0000};
        vecs[1]  = '{4'b1111,  1, 4'b1111, 4'b1111, 4'b0000};
        vecs[2]  = '{4'b1111,  1, 4'b1111, 4'b0000, 4'b0000};
        vecs[3]  = '{4'b0000, 17, 4'b1111, 4'b0000, 4'b0000};
        vecs[4]  = '{4'b0000,  1, 4'b0000, 4'b0000, 4'b1111};
        vecs[5]  = '{4'b0000,  1, 4'b0000, 4'b0000, 4'b0000};
        vecs[6]  = '{4'b0001, 17, 4'b0000, 4'b0000, 4'b0000};
        vecs[7]  = '{4'b0001,  1, 4'b0001, 4'b0001, 4'b0000};
        vecs[8]  = '{4'b0001,107, 4'b0001, 4'b0000, 4'b0000};
        vecs[9]  = '{4'b1001, 17, 4'b0001, 4'b0000, 4'b0000};
        vecs[10] = '{4'b1001,  1, 4'b1001, 4'b1000, 4'b0000};
        vecs[11] = '{4'b1001,  2, 4'b1001, 4'b0000, 4'b0000};
        vecs[12] = '{4'b0110, 17, 4'b1001, 4'b0000, 4'b0000};
        vecs[13] = '{4'b0110,  1, 4'b0110, 4'b0110, 4'b1001};
        vecs[14] = '{4'b0110,  1, 4'b0110, 4'b0000, 4'b0000};
        vecs[15] = '{4'b0000, 18, 4'b0000, 4'b0000, 4'b0110};
        vecs[16] = '{4'b0000,  1, 4'b0000, 4'b0000, 4'b0000};

        // Reset held with all switches high: outputs stay 0.
        bus.swt_raw = 4'b1111;
        rstb        = 1'b0;
        for (int i = 0; i < 12; i++) begin
            step();
            chk("reset_hold", 4'b0000, 4'b0000, 4'b0000);
        end
        rstb = 1'b1;

        // Table: release/re-debounce, clean press, simultaneous change.
        for (int v = 0; v < 17; v++) begin
            bus.swt_raw = vecs[v].raw;
            quiet = 1'b1;
            for (int e = 1; e <= vecs[v].n_edges; e++) begin
                step();
                if (e < vecs[v].n_edges && (bus.swt_rise !== 4'b0000 || bus.swt_fall !== 4'b0000))
                    quiet = 1'b0;
            end
            if (vecs[v].n_edges > 1) begin
                checks++;
                if (!quiet) begin
                    errors++;
                    $display("FAIL vec%0d_quiet: got an early pulse, want none before the last edge", v);
                end
            end
            chk($sformatf("vec%0d", v), vecs[v].db, vecs[v].rise, vecs[v].fall);
            $display("vec %0d raw=%b edges=%0d db=%b rise=%b fall=%b",
                     v, vecs[v].raw, vecs[v].n_edges, bus.swt_db, bus.swt_rise, bus.swt_fall);
        end

        // Bounce: raw[1] toggles every 5 cycles for 100 cycles, then holds 1.
        for (int c = 0; c < 100; c++) begin
            bus.swt_raw = ((c / 5) % 2 == 0) ? 4'b0010 : 4'b0000;
            step();
            chk("bounce", 4'b0000, 4'b0000, 4'b0000);
        end
        bus.swt_raw = 4'b0010;
        for (int e = 1; e <= 19; e++) begin
            step();
            if (e == 17) chk("bounce_e17", 4'b0000, 4'b0000, 4'b0000);
            if (e == 18) chk("bounce_e18", 4'b0010, 4'b0010, 4'b0000);
            if (e == 19) chk("bounce_e19", 4'b0010, 4'b0000, 4'b0000);
        end
        $display("bounce settle db=%b", bus.swt_db);
        bus.swt_raw = 4'b0000;
        for (int e = 1; e <= 18; e++) step();
        chk("bounce_release", 4'b0000, 4'b0000, 4'b0010);
        step();

        // Glitch of 15 cycles on raw[2]: nothing may change.
        for (int e = 1; e <= 45; e++) begin
            bus.swt_raw = (e <= 15) ? 4'b0100 : 4'b0000;
            step();
            chk("glitch15", 4'b0000, 4'b0000, 4'b0000);
        end
        $display("glitch15 db=%b", bus.swt_db);

        // Glitch of 16 cycles: accepted on edge 18, released on edge 34.
        for (int e = 1; e <= 40; e++) begin
            bus.swt_raw = (e <= 16) ? 4'b0100 : 4'b0000;
            step();
            edb   = (e >= 18 && e < 34) ? 4'b0100 : 4'b0000;
            erise = (e == 18) ? 4'b0100 : 4'b0000;
            efall = (e == 34) ? 4'b0100 : 4'b0000;
            chk($sformatf("glitch16_e%0d", e), edb, erise, efall);
        end
        $display("glitch16 db=%b", bus.swt_db);

        // Reset in the middle of a debounce discards the pending count.
        bus.swt_raw = 4'b1000;
        for (int e = 0; e < 10; e++) step();
        rstb = 1'b0;
        #1;
        chk("midreset_async", 4'b0000, 4'b0000, 4'b0000);
        step();
        step();
        chk("midreset_hold", 4'b0000, 4'b0000, 4'b0000);
        rstb = 1'b1;
        for (int e = 1; e <= 19; e++) begin
            step();
            if (e == 17) chk("midreset_e17", 4'b0000, 4'b0000, 4'b0000);
            if (e == 18) chk("midreset_e18", 4'b1000, 4'b1000, 4'b0000);
            if (e == 19) chk("midreset_e19", 4'b1000, 4'b0000, 4'b0000);
        end
        $display("midreset redebounce db=%b", bus.swt_db);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
